xnor_pop_scheduler: RTL and testbench
=====================================

// Module: xnor_pop_scheduler
//
// PURPOSE
// Sequences a time-multiplexed binary neuron over one XNOR-popcount datapath slice.
// The fan-in is split into NUM_CHUNKS chunks of CHUNK bits each:
//   - issues one chunk read address per cycle to the activation/weight buffers;
//   - accumulates the per-chunk popcount returned by the datapath;
//   - compares the total against a latched threshold and produces the neuron's output bit.
// It sits between the layer controller (start/done handshake) and the buffers plus XNORPop slice.
//
// PARAMETERS
// CHUNK       64                             bits per chunk (datapath pop_size)
// NUM_CHUNKS  9                              chunks per neuron (576-bit fan-in by default)
// POP_W       $clog2(CHUNK+1)                width of pop_in; must hold the value CHUNK
// ACC_W       $clog2(CHUNK*NUM_CHUNKS+1)     accumulator, threshold and acc_out width
// IDX_W       (NUM_CHUNKS>1)?$clog2(NUM_CHUNKS):1   chunk address width
//
// PORTS
// clk        in   1      rising-edge clock
// rst        in   1      synchronous, active-high reset
// start      in   1      request one neuron evaluation; honoured only in IDLE
// threshold  in   ACC_W  sampled on the accepted start cycle
// busy       out  1      high in RUN and DRAIN
// rd_en      out  1      buffer read strobe; high in RUN only
// rd_addr    out  IDX_W  chunk index; 0..NUM_CHUNKS-1 during RUN, 0 otherwise
// pop_in     in   POP_W  datapath popcount for the chunk read on the previous cycle
// done       out  1      one-cycle pulse: acc_out and bit_out updated
// acc_out    out  ACC_W  total popcount of the last evaluation; held until the next done
// bit_out    out  1      (acc_out >= threshold latched at start); held with acc_out
//
// BEHAVIOUR
// - Reset: state=IDLE; busy, rd_en, done, bit_out = 0; rd_addr, acc_out, internal acc/idx = 0.
//   Reset also clears the valid pipeline register.
// - FSM states IDLE -> RUN -> DRAIN -> IDLE.
//   - IDLE: on start=1, latch threshold, clear acc and idx, go to RUN.
//   - RUN: rd_en=1, rd_addr=idx, idx++.
//     - If idx==NUM_CHUNKS-1, go to DRAIN (a RUN lasts exactly NUM_CHUNKS cycles).
//   - DRAIN: one cycle, go to IDLE.
// - Read latency is fixed at 1 cycle, so pop_in is valid the cycle after rd_en.
//   - vld is rd_en delayed one cycle.
//   - While vld=1, acc <= acc + pop_in (zero-extended to ACC_W).
//   - pop_in is ignored while vld=0.
// - On the DRAIN->IDLE edge:
//   - acc_out <= acc + pop_in;
//   - bit_out <= (acc + pop_in) >= thr_latched;
//   - done <= 1 for exactly one cycle.
// - Latency: start accepted at edge E0; done=1 in cycle E0+NUM_CHUNKS+2.
//   This gives NUM_CHUNKS+2 clocks start-to-done.
// - Back-to-back: start may be high in the same cycle done is high; it is accepted (state is IDLE).
// - start while busy is ignored and is not queued; the threshold is not re-sampled.
// - NUM_CHUNKS=1: RUN lasts one cycle with rd_addr=0, then DRAIN.
// - Overflow: ACC_W is sized for all-ones input (CHUNK*NUM_CHUNKS), so no wrap can occur.
//   pop_in > CHUNK is a protocol violation; the result is undefined but the FSM still completes.
// - rst mid-operation (RUN or DRAIN):
//   - return to IDLE next cycle;
//   - no done pulse;
//   - acc_out and bit_out cleared to 0.
// - acc_out and bit_out change only on done or rst.
//
// TESTING
// 1. Reset and idle: after rst, all outputs are 0; start=0 for 20 cycles -> rd_en never rises.
// 2. All-ones evaluation (CHUNK=64, N=9): pop_in=64 each valid cycle, threshold=288
//    -> rd_addr 0..8 on consecutive cycles, done at start+11, acc_out=576, bit_out=1.
// 3. Threshold boundary: pop_in=32 each chunk (acc=288)
//    -> threshold=288 gives bit_out=1; threshold=289 gives bit_out=0.
// 4. Busy-start and back-to-back:
//    - start pulsed mid-RUN with a new threshold -> ignored; the result uses the first threshold.
//    - start on the done cycle -> a new RUN begins the next cycle with acc cleared.
// 5. Reset mid-RUN at rd_addr=4 -> IDLE next cycle, no done, acc_out=0.
//    The following start produces a clean full result.
// 6. NUM_CHUNKS=1 build: pop_in=0, threshold=0 -> done 3 cycles after start, acc_out=0, bit_out=1.

Source files
------------

// File: rtl/xnor_pop_scheduler.sv
// xnor_pop_scheduler
// Drives one time-multiplexed binary neuron over a single XNOR-popcount slice.
// Each accepted start walks the chunk addresses 0..NUM_CHUNKS-1, one per cycle.
// It accumulates the popcount that returns one cycle later for each chunk.
// The final total is compared against the threshold captured at start.
// The result is published with a one-cycle done pulse.

module xnor_pop_scheduler #(
    parameter int CHUNK      = 64,
    parameter int NUM_CHUNKS = 9,
    parameter int POP_W      = $clog2(CHUNK + 1),
    parameter int ACC_W      = $clog2(CHUNK * NUM_CHUNKS + 1),
    parameter int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] threshold,
    output logic             busy,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr,
    input  logic [POP_W-1:0] pop_in,
    output logic             done,
    output logic [ACC_W-1:0] acc_out,
    output logic             bit_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] thr_latched;
    logic [ACC_W-1:0] acc_sum;
    logic [IDX_W-1:0] idx;
    logic             vld;

    // The chunk index register doubles as the read address; it is only non-zero during RUN
    assign rd_addr = idx;

    // Running total including the popcount currently presented by the datapath
    always_comb begin
        acc_sum = acc + ACC_W'(pop_in);
    end

    // Control FSM, read-valid pipeline, accumulator and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            rd_en       <= 1'b0;
            done        <= 1'b0;
            bit_out     <= 1'b0;
            acc_out     <= '0;
            acc         <= '0;
            idx         <= '0;
            thr_latched <= '0;
            vld         <= 1'b0;
        end else begin
            done <= 1'b0;
            vld  <= rd_en;
            if (vld) begin
                acc <= acc_sum;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        thr_latched <= threshold;
                        acc         <= '0;
                        idx         <= '0;
                        rd_en       <= 1'b1;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        idx <= idx + IDX_ONE;
                    end
                end
                DRAIN: begin
                    acc_out <= acc_sum;
                    bit_out <= (acc_sum >= thr_latched);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    rd_en <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xnor_pop_scheduler.sv
// tb_xnor_pop_scheduler
// Directed checks of the neuron scheduler: a default 9-chunk instance plus a 1-chunk instance.

module tb_xnor_pop_scheduler;

    localparam logic [6:0] JUNK = 7'd63;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // 9-chunk instance (ACC_W=10, POP_W=7, IDX_W=4)
    logic       start = 1'b0;
    logic [9:0] threshold = '0;
    logic       busy;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [6:0] pop_in = JUNK;
    logic       done;
    logic [9:0] acc_out;
    logic       bit_out;

    // 1-chunk instance (ACC_W=7, POP_W=7, IDX_W=1)
    logic       start1 = 1'b0;
    logic [6:0] thr1 = '0;
    logic       busy1;
    logic       rd_en1;
    logic [0:0] rd_addr1;
    logic [6:0] pop1 = JUNK;
    logic       done1;
    logic [6:0] acc1;
    logic       bit1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] pop_tab [9];
    logic       obs_en   [1:11];
    logic [3:0] obs_addr [1:11];
    logic       obs_busy [1:11];
    logic       obs_done [1:11];
    logic [9:0] obs_acc;
    logic       obs_bit;

    xnor_pop_scheduler u_dut (
        .clk(clk), .rst(rst), .start(start), .threshold(threshold),
        .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .pop_in(pop_in),
        .done(done), .acc_out(acc_out), .bit_out(bit_out)
    );

    xnor_pop_scheduler #(.CHUNK(64), .NUM_CHUNKS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .threshold(thr1),
        .busy(busy1), .rd_en(rd_en1), .rd_addr(rd_addr1), .pop_in(pop1),
        .done(done1), .acc_out(acc1), .bit_out(bit1)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one evaluation on the 9-chunk instance and records outputs for cycles 1..11.
    // Cycle k after the accepting edge carries pop_tab[k-2]; other cycles carry JUNK.
    // Returns in the done cycle (cycle 11) without advancing past it.
    task automatic run_eval(input logic [9:0] thr, input int mid_cyc, input logic [9:0] mid_thr);
        start     = 1'b1;
        threshold = thr;
        pop_in    = JUNK;
        tick();
        start     = 1'b0;
        threshold = 10'h3FF;
        for (int c = 1; c <= 11; c++) begin
            obs_en[c]   = rd_en;
            obs_addr[c] = rd_addr;
            obs_busy[c] = busy;
            obs_done[c] = done;
            if (c == 11) begin
                obs_acc = acc_out;
                obs_bit = bit_out;
                pop_in  = JUNK;
            end else begin
                pop_in    = (c >= 2 && c <= 10) ? pop_tab[c-2] : JUNK;
                start     = (c == mid_cyc);
                threshold = (c == mid_cyc) ? mid_thr : 10'h3FF;
                tick();
            end
        end
        start     = 1'b0;
        threshold = 10'h3FF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({busy, rd_en, done, bit_out} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got busy/rd_en/done/bit=%b expected 0000", {busy, rd_en, done, bit_out});
        end
        n_checks++;
        if (acc_out !== 10'd0 || rd_addr !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got acc_out=%0d rd_addr=%0d expected 0 0", acc_out, rd_addr);
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (rd_en !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL idle_quiet: cycle %0d got rd_en=%b busy=%b expected 0 0", i, rd_en, busy);
            end
            tick();
        end
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < 9; i++) pop_tab[i] = 7'd64;
        run_eval(10'd288, 0, 10'd0);
        for (int c = 1; c <= 11; c++) begin
            n_checks++;
            if (obs_en[c] !== (c <= 9)) begin
                n_fail++;
                $display("[TB] FAIL all_ones_rd_en: cycle %0d got %b expected %b", c, obs_en[c], (c <= 9));
            end
            n_checks++;
            if (obs_addr[c] !== ((c <= 9) ? 4'(c - 1) : 4'd0)) begin
                n_fail++;
                $display("[TB] FAIL all_ones_rd_addr: cycle %0d got %0d expected %0d", c, obs_addr[c], (c <= 9) ? c - 1 : 0);
            end
            n_checks++;
            if (obs_busy[c] !== (c <= 10)) begin
                n_fail++;
                $display("[TB] FAIL all_ones_busy: cycle %0d got %b expected %b", c, obs_busy[c], (c <= 10));
            end
            n_checks++;
            if (obs_done[c] !== (c == 11)) begin
                n_fail++;
                $display("[TB] FAIL all_ones_done: cycle %0d got %b expected %b", c, obs_done[c], (c == 11));
            end
        end
        n_checks++;
        if (obs_acc !== 10'd576 || obs_bit !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL all_ones_result: got acc=%0d bit=%b expected 576 1", obs_acc, obs_bit);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || acc_out !== 10'd576 || bit_out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL all_ones_hold: got done=%b acc=%0d bit=%b expected 0 576 1", done, acc_out, bit_out);
        end
    endtask

    task automatic test_threshold_boundary();
        for (int i = 0; i < 9; i++) pop_tab[i] = 7'd32;
        run_eval(10'd288, 0, 10'd0);
        n_checks++;
        if (obs_acc !== 10'd288 || obs_bit !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL thr_equal: got acc=%0d bit=%b expected 288 1", obs_acc, obs_bit);
        end
        tick();
        run_eval(10'd289, 0, 10'd0);
        n_checks++;
        if (obs_acc !== 10'd288 || obs_bit !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL thr_above: got acc=%0d bit=%b expected 288 0", obs_acc, obs_bit);
        end
        tick();
    endtask

    task automatic test_mixed_chunks();
        // 64+0+5+10+20+30+40+50+60 = 279
        pop_tab = '{7'd64, 7'd0, 7'd5, 7'd10, 7'd20, 7'd30, 7'd40, 7'd50, 7'd60};
        run_eval(10'd280, 0, 10'd0);
        n_checks++;
        if (obs_acc !== 10'd279 || obs_bit !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mixed_below: got acc=%0d bit=%b expected 279 0", obs_acc, obs_bit);
        end
        tick();
        run_eval(10'd279, 0, 10'd0);
        n_checks++;
        if (obs_acc !== 10'd279 || obs_bit !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mixed_equal: got acc=%0d bit=%b expected 279 1", obs_acc, obs_bit);
        end
        tick();
    endtask

    task automatic test_busy_start();
        for (int i = 0; i < 9; i++) pop_tab[i] = 7'd32;
        run_eval(10'd100, 4, 10'd300);
        n_checks++;
        if (obs_en[5] !== 1'b1 || obs_addr[5] !== 4'd4 || obs_addr[6] !== 4'd5) begin
            n_fail++;
            $display("[TB] FAIL busy_start_seq: got en=%b addr5=%0d addr6=%0d expected 1 4 5", obs_en[5], obs_addr[5], obs_addr[6]);
        end
        n_checks++;
        if (obs_done[11] !== 1'b1 || obs_done[10] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL busy_start_done: got done10=%b done11=%b expected 0 1", obs_done[10], obs_done[11]);
        end
        n_checks++;
        if (obs_acc !== 10'd288 || obs_bit !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL busy_start_thr: got acc=%0d bit=%b expected 288 1", obs_acc, obs_bit);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL busy_start_queued: got busy=%b rd_en=%b expected 0 0", busy, rd_en);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) pop_tab[i] = 7'd32;
        run_eval(10'd100, 0, 10'd0);
        n_checks++;
        if (obs_acc !== 10'd288 || obs_bit !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: got acc=%0d bit=%b expected 288 1", obs_acc, obs_bit);
        end
        for (int i = 0; i < 9; i++) pop_tab[i] = 7'd1;
        run_eval(10'd10, 0, 10'd0);
        n_checks++;
        if (obs_en[1] !== 1'b1 || obs_addr[1] !== 4'd0 || obs_busy[1] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_restart: got en=%b addr=%0d busy=%b expected 1 0 1", obs_en[1], obs_addr[1], obs_busy[1]);
        end
        n_checks++;
        if (obs_acc !== 10'd9 || obs_bit !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: got acc=%0d bit=%b expected 9 0", obs_acc, obs_bit);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 9; i++) pop_tab[i] = 7'd64;
        start     = 1'b1;
        threshold = 10'd200;
        tick();
        start     = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            pop_in = (c >= 2) ? pop_tab[c-2] : JUNK;
            tick();
        end
        n_checks++;
        if (rd_addr !== 4'd4 || rd_en !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midrst_pos: got rd_addr=%0d rd_en=%b expected 4 1", rd_addr, rd_en);
        end
        pop_in = JUNK;
        rst    = 1'b1;
        tick();
        n_checks++;
        if ({busy, rd_en, done, bit_out} !== 4'b0000 || rd_addr !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL midrst_idle: got busy/rd_en/done/bit=%b rd_addr=%0d expected 0000 0", {busy, rd_en, done, bit_out}, rd_addr);
        end
        n_checks++;
        if (acc_out !== 10'd0) begin
            n_fail++;
            $display("[TB] FAIL midrst_acc: got %0d expected 0", acc_out);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || rd_en !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL midrst_no_done: cycle %0d got done=%b rd_en=%b expected 0 0", i, done, rd_en);
            end
        end
        run_eval(10'd288, 0, 10'd0);
        n_checks++;
        if (obs_done[11] !== 1'b1 || obs_acc !== 10'd576 || obs_bit !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midrst_recover: got done=%b acc=%0d bit=%b expected 1 576 1", obs_done[11], obs_acc, obs_bit);
        end
        tick();
    endtask

    task automatic test_single_chunk();
        start1 = 1'b1;
        thr1   = 7'd0;
        tick();
        start1 = 1'b0;
        thr1   = 7'h7F;
        n_checks++;
        if (rd_en1 !== 1'b1 || rd_addr1 !== 1'b0 || busy1 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL n1_run: got rd_en=%b addr=%0d busy=%b expected 1 0 1", rd_en1, rd_addr1, busy1);
        end
        pop1 = 7'd17;
        tick();
        n_checks++;
        if (rd_en1 !== 1'b0 || busy1 !== 1'b1 || done1 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL n1_drain: got rd_en=%b busy=%b done=%b expected 0 1 0", rd_en1, busy1, done1);
        end
        pop1 = 7'd0;
        tick();
        n_checks++;
        if (done1 !== 1'b1 || acc1 !== 7'd0 || bit1 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL n1_zero: got done=%b acc=%0d bit=%b expected 1 0 1", done1, acc1, bit1);
        end
        pop1   = 7'd17;
        start1 = 1'b1;
        thr1   = 7'd41;
        tick();
        start1 = 1'b0;
        thr1   = 7'h00;
        pop1   = 7'd17;
        tick();
        pop1 = 7'd40;
        tick();
        n_checks++;
        if (done1 !== 1'b1 || acc1 !== 7'd40 || bit1 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL n1_forty: got done=%b acc=%0d bit=%b expected 1 40 0", done1, acc1, bit1);
        end
        pop1 = JUNK;
        tick();
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_threshold_boundary();
        test_mixed_chunks();
        test_busy_start();
        test_back_to_back();
        test_reset_mid_run();
        test_single_chunk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
